// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: small instruction FIFO feeding a single-issue pipeline,
// with a shift-register scoreboard that blocks RAW-dependent issue until write-back.
module pipe_issue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_rs1,
  input  logic [3:0] in_rs2,
  input  logic [3:0] in_rd,
  input  logic [3:0] in_func,
  input  logic [7:0] in_addr,
  input  logic       flush,
  output logic       iss_valid,
  output logic [3:0] iss_rs1,
  output logic [3:0] iss_rs2,
  output logic [3:0] iss_rd,
  output logic [3:0] iss_func,
  output logic [7:0] iss_addr,
  output logic       illegal,
  output logic [7:0] stall_cnt,
  output logic       busy
);

  localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SBN    = (WB_LAT > 1) ? WB_LAT - 1 : 1;
  localparam bit          USE_SB = (WB_LAT > 1);

  logic [3:0] q_rs1  [DEPTH];
  logic [3:0] q_rs2  [DEPTH];
  logic [3:0] q_rd   [DEPTH];
  logic [3:0] q_func [DEPTH];
  logic [7:0] q_addr [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // sb_v[i]/sb_rd[i]: destination issued i+1 edges ago, still awaiting write-back
  logic       sb_v  [SBN];
  logic [3:0] sb_rd [SBN];

  logic [3:0] head_rs1, head_rs2, head_rd, head_func;
  logic [7:0] head_addr;
  logic q_empty, q_full, push, pop;
  logic head_legal, head_bad, hazard, issue, drop, stall, sb_any;

  always_comb begin
    head_rs1  = q_rs1[rd_ptr];
    head_rs2  = q_rs2[rd_ptr];
    head_rd   = q_rd[rd_ptr];
    head_func = q_func[rd_ptr];
    head_addr = q_addr[rd_ptr];
  end

  assign q_empty    = (count == '0);
  assign q_full     = (count == (AW+1)'(DEPTH));
  assign in_ready   = !q_full && !flush;
  assign push       = in_valid && in_ready;
  assign head_legal = !q_empty && (head_func < 4'd12);
  assign head_bad   = !q_empty && (head_func >= 4'd12);

  always_comb begin
    hazard = 1'b0;
    sb_any = 1'b0;
    for (int unsigned i = 0; i < SBN; i++) begin
      if (sb_v[i]) begin
        sb_any = 1'b1;
        if (sb_rd[i] == head_rs1 || sb_rd[i] == head_rs2) hazard = 1'b1;
      end
    end
  end

  // Illegal heads are discarded even when they would otherwise be hazarded
  assign issue = head_legal && !hazard && !flush;
  assign drop  = head_bad && !flush;
  assign stall = head_legal && hazard && !flush;
  assign pop   = issue || drop;
  assign busy  = !q_empty || sb_any;

  always_ff @(posedge clk) begin
    if (push) begin
      q_rs1[wr_ptr]  <= in_rs1;
      q_rs2[wr_ptr]  <= in_rs2;
      q_rd[wr_ptr]   <= in_rd;
      q_func[wr_ptr] <= in_func;
      q_addr[wr_ptr] <= in_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
      illegal   <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
      stall_cnt <= '0;
    end else begin
      iss_valid <= issue;
      illegal   <= drop;
      if (issue) begin
        iss_rs1  <= head_rs1;
        iss_rs2  <= head_rs2;
        iss_rd   <= head_rd;
        iss_func <= head_func;
        iss_addr <= head_addr;
      end
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SBN; i++) begin
        sb_v[i]  <= 1'b0;
        sb_rd[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < SBN; i++) begin
        sb_v[i]  <= 1'b0;
        sb_rd[i] <= '0;
      end
    end else begin
      sb_v[0]  <= issue && USE_SB;
      sb_rd[0] <= head_rd;
      for (int unsigned i = 1; i < SBN; i++) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: independent/dependent streams, full queue,
// illegal drop, flush and asynchronous reset, with hand-computed expectations.
module tb_pipe_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_rs1, in_rs2, in_rd, in_func;
  logic [7:0] in_addr;
  logic       flush;
  logic       iss_valid;
  logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0] iss_addr;
  logic       illegal;
  logic [7:0] stall_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.DEPTH(4), .WB_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func),
    .in_addr(in_addr), .flush(flush), .iss_valid(iss_valid),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_func(iss_func),
    .iss_addr(iss_addr), .illegal(illegal), .stall_cnt(stall_cnt), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rd,
                      input logic [3:0] fn, input logic [7:0] ad);
    in_valid = 1'b1;
    in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_func = fn; in_addr = ad;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_func = '0; in_addr = '0;
    #3;
    check("rst_iss_valid", 32'(iss_valid), 0);
    check("rst_illegal",   32'(illegal), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_iss_addr",  32'(iss_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready), 1);

    // Independent stream: two back-to-back issues
    push(4'd3, 4'd5, 4'd10, 4'd0, 8'd125); step();
    push(4'd3, 4'd8, 4'd12, 4'd2, 8'd126); step();
    check("ind_v0",    32'(iss_valid), 1);
    check("ind_rd0",   32'(iss_rd), 10);
    check("ind_rs1_0", 32'(iss_rs1), 3);
    check("ind_rs2_0", 32'(iss_rs2), 5);
    check("ind_fn0",   32'(iss_func), 0);
    check("ind_ad0",   32'(iss_addr), 125);
    idle(); step();
    check("ind_v1",    32'(iss_valid), 1);
    check("ind_rd1",   32'(iss_rd), 12);
    check("ind_rs2_1", 32'(iss_rs2), 8);
    check("ind_fn1",   32'(iss_func), 2);
    check("ind_ad1",   32'(iss_addr), 126);
    step();
    check("ind_v2",    32'(iss_valid), 0);
    check("ind_hold",  32'(iss_rd), 12);
    check("ind_stall", 32'(stall_cnt), 0);
    check("ind_busy1", 32'(busy), 1);
    step();
    check("ind_busy0", 32'(busy), 0);
    repeat (3) step();

    // RAW hazard: SUB waits WB_LAT edges after ADD
    push(4'd3, 4'd5, 4'd10, 4'd0, 8'd1); step();
    push(4'd10, 4'd5, 4'd14, 4'd1, 8'd2); step();
    check("raw_add_v",  32'(iss_valid), 1);
    check("raw_add_rd", 32'(iss_rd), 10);
    idle(); step();
    check("raw_s1_v",   32'(iss_valid), 0);
    check("raw_s1_cnt", 32'(stall_cnt), 1);
    step();
    check("raw_s2_v",   32'(iss_valid), 0);
    check("raw_s2_cnt", 32'(stall_cnt), 2);
    step();
    check("raw_sub_v",   32'(iss_valid), 1);
    check("raw_sub_rd",  32'(iss_rd), 14);
    check("raw_sub_rs1", 32'(iss_rs1), 10);
    check("raw_sub_fn",  32'(iss_func), 1);
    check("raw_cnt",     32'(stall_cnt), 2);
    repeat (3) step();

    // Full queue: dependency chain keeps the head stalled while the queue fills
    push(4'd9, 4'd9, 4'd1, 4'd0, 8'h31); step();
    push(4'd1, 4'd0, 4'd2, 4'd1, 8'h32); step();
    check("full_e1_v",  32'(iss_valid), 1);
    check("full_e1_ad", 32'(iss_addr), 32'h31);
    push(4'd2, 4'd0, 4'd3, 4'd2, 8'h33); step();
    push(4'd3, 4'd0, 4'd4, 4'd3, 8'h34); step();
    push(4'd4, 4'd0, 4'd5, 4'd4, 8'h35); step();
    check("full_e2_ad", 32'(iss_addr), 32'h32);
    push(4'd5, 4'd0, 4'd6, 4'd5, 8'h36); step();
    check("full_rdy0",  32'(in_ready), 0);
    push(4'd0, 4'd0, 4'd7, 4'd6, 8'h37); step();
    check("full_rdy1",  32'(in_ready), 0);
    check("full_nov",   32'(iss_valid), 0);
    step();
    check("full_e3_v",  32'(iss_valid), 1);
    check("full_e3_ad", 32'(iss_addr), 32'h33);
    check("full_rdy2",  32'(in_ready), 1);
    idle();
    for (int e = 8; e <= 19; e++) begin
      step();
      if (e == 10 || e == 13 || e == 16) begin
        check("full_seq_v",  32'(iss_valid), 1);
        check("full_seq_ad", 32'(iss_addr), 32'h34 + 32'((e - 10) / 3));
      end else begin
        check("full_seq_idle", 32'(iss_valid), 0);
      end
    end
    check("full_busy",  32'(busy), 0);
    check("full_stall", 32'(stall_cnt), 12);
    repeat (2) step();

    // Illegal func between two legal instructions; func 11 is the top legal code
    push(4'd0, 4'd0, 4'd11, 4'd5, 8'h41); step();
    push(4'd11, 4'd0, 4'd2, 4'd13, 8'h42); step();
    check("ill_l1_v",  32'(iss_valid), 1);
    check("ill_l1_ad", 32'(iss_addr), 32'h41);
    check("ill_l1_il", 32'(illegal), 0);
    push(4'd2, 4'd2, 4'd12, 4'd11, 8'h43); step();
    check("ill_drop_v",  32'(iss_valid), 0);
    check("ill_drop_il", 32'(illegal), 1);
    check("ill_hold_ad", 32'(iss_addr), 32'h41);
    idle(); step();
    check("ill_l2_v",  32'(iss_valid), 1);
    check("ill_l2_ad", 32'(iss_addr), 32'h43);
    check("ill_l2_fn", 32'(iss_func), 11);
    check("ill_l2_il", 32'(illegal), 0);
    step();
    check("ill_end_v",   32'(iss_valid), 0);
    check("ill_end_il",  32'(illegal), 0);
    check("ill_stall",   32'(stall_cnt), 12);
    repeat (3) step();

    // Flush with three queued entries and an outstanding destination
    push(4'd0, 4'd0, 4'd13, 4'd0, 8'h51); step();
    push(4'd13, 4'd0, 4'd14, 4'd1, 8'h52); step();
    check("fl_a_ad", 32'(iss_addr), 32'h51);
    push(4'd0, 4'd0, 4'd1, 4'd2, 8'h53); step();
    check("fl_s1", 32'(stall_cnt), 13);
    push(4'd0, 4'd0, 4'd2, 4'd3, 8'h54); step();
    check("fl_s2", 32'(stall_cnt), 14);
    push(4'd0, 4'd0, 4'd3, 4'd4, 8'h55); step();
    check("fl_b_v",  32'(iss_valid), 1);
    check("fl_b_ad", 32'(iss_addr), 32'h52);
    idle(); flush = 1'b1; #1;
    check("fl_rdy", 32'(in_ready), 0);
    step();
    flush = 1'b0;
    check("fl_busy",  32'(busy), 0);
    check("fl_v",     32'(iss_valid), 0);
    check("fl_stall", 32'(stall_cnt), 14);
    push(4'd14, 4'd14, 4'd15, 4'd2, 8'h5F); step();
    idle(); step();
    check("fl_dep_v",     32'(iss_valid), 1);
    check("fl_dep_ad",    32'(iss_addr), 32'h5F);
    check("fl_dep_stall", 32'(stall_cnt), 14);
    for (int k = 0; k < 4; k++) begin
      step();
      check("fl_after_v", 32'(iss_valid), 0);
    end
    check("fl_end_busy", 32'(busy), 0);

    // Asynchronous reset mid-operation
    push(4'd0, 4'd0, 4'd3, 4'd4, 8'h61); step();
    push(4'd0, 4'd0, 4'd4, 4'd4, 8'h62); step();
    idle();
    check("ar_pre_v", 32'(iss_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_v",     32'(iss_valid), 0);
    check("ar_rdy",   32'(in_ready), 1);
    check("ar_busy",  32'(busy), 0);
    check("ar_addr",  32'(iss_addr), 0);
    check("ar_stall", 32'(stall_cnt), 0);
    check("ar_il",    32'(illegal), 0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ar_post_v", 32'(iss_valid), 0);
    end
    check("ar_post_busy", 32'(busy), 0);
    push(4'd0, 4'd0, 4'd5, 4'd7, 8'h70); step();
    idle(); step();
    check("ar_new_v",  32'(iss_valid), 1);
    check("ar_new_ad", 32'(iss_addr), 32'h70);
    check("ar_new_fn", 32'(iss_func), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_issue_ctrl.md
PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, instruction queue entries (power of two, 2..16).
REQ-002 Parameter: WB_LAT, 3, cycles from issue until the destination register is written in the regbank.
REQ-003 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  requester presents an instruction.
REQ-006 Port: in_ready  output  1  queue can accept an instruction this cycle.
REQ-007 Port: in_rs1, in_rs2, in_rd  input  4 each  source and destination register indices.
REQ-008 Port: in_func  input  4  ALU function code.
REQ-009 Port: in_addr  input  8  memory write address.
REQ-010 Port: flush  input  1  synchronous discard of all queued and in-flight tracking state.
REQ-011 Port: iss_valid  output  1  registered one-cycle issue strobe to the pipeline.
REQ-012 Port: iss_rs1, iss_rs2, iss_rd, iss_func  output  4 each  registered issued fields.
REQ-013 Port: iss_addr  output  8  registered issued address.
REQ-014 Port: illegal  output  1  registered one-cycle pulse when the head entry is dropped as illegal.
REQ-015 Port: stall_cnt  output  8  saturating count of hazard-stall cycles.
REQ-016 Port: busy  output  1  queue non-empty or scoreboard non-empty.

Function
REQ-017 in_ready SHALL be 1 exactly when the queue is not full and flush is 0; an entry is accepted on an edge where in_valid and in_ready are both 1.
REQ-018 There SHALL be no bypass: an entry accepted at edge k can drive iss_valid=1 after edge k+1 at the earliest.
REQ-019 A simultaneous accept and issue with the queue neither empty nor full SHALL leave the occupancy unchanged; when the queue is full, in_ready=0 even if an issue occurs in the same cycle.
REQ-020 Legal func codes SHALL be 0..11 (ADD, SUB, MUL, SELA, SELB, AND, OR, XOR, NEGA, NEGB, SRA, SLA).
REQ-021 If the head entry has func 12..15, it SHALL be popped without issue, illegal SHALL pulse for one cycle, and the scoreboard SHALL be unchanged.
REQ-022 The scoreboard SHALL track the rd of each instruction issued in the last WB_LAT-1 edges.
REQ-023 A legal head entry SHALL be hazarded when its rs1 or rs2 equals any tracked rd.
REQ-024 A legal head entry SHALL issue at an edge where it is not hazarded: iss_* are loaded from the head, iss_valid=1 for one cycle, the entry is popped, and its rd enters the scoreboard.
REQ-025 An instruction issued at edge k SHALL block dependent issue at edges k+1..k+WB_LAT-1; a dependent instruction can issue at edge k+WB_LAT.
REQ-026 Issue SHALL be strictly in order: a hazarded head blocks all younger entries, and at most one instruction issues per cycle.
REQ-027 When no issue occurs, iss_valid SHALL be 0 and iss_* fields SHALL hold their last values.
REQ-028 stall_cnt SHALL increment on each cycle in which a legal head is hazarded, and SHALL saturate at 255.
REQ-029 flush=1 SHALL, at the next edge, empty the queue, clear the scoreboard, and force iss_valid=0 and illegal=0; stall_cnt is not affected.

Reset
REQ-030 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, reach this state: queue empty, scoreboard clear, iss_valid=0, illegal=0, iss_*=0, stall_cnt=0, busy=0, and in_ready=1 once rst_n=1.
REQ-031 A reset asserted mid-operation SHALL discard all queued instructions; no issue strobe SHALL occur until a new instruction is accepted after rst_n deasserts.

Verification
REQ-032 Independent stream: push ADD(rs1=3, rs2=5, rd=10, addr=125), then MUL(3, 8, rd=12, addr=126) on consecutive cycles -> iss_valid on two consecutive cycles, fields match, stall_cnt=0.
REQ-033 RAW hazard: push ADD(3, 5, rd=10), then SUB(rs1=10, rs2=5, rd=14) back-to-back -> SUB issues exactly WB_LAT edges after ADD, and stall_cnt=2.
REQ-034 Full queue: hold the head hazarded and push 4 entries -> in_ready=0 after the 4th; a 5th in_valid is not accepted; entries issue in FIFO order with no loss.
REQ-035 Illegal func: push func=13 between two legal instructions -> illegal pulses once, iss_valid is never asserted for it, and the legal instructions issue in order.
REQ-036 Flush: with 3 queued entries and one outstanding scoreboard rd, assert flush for 1 cycle -> busy=0 next cycle, a following dependent instruction issues without a stall, and stall_cnt is unchanged.
REQ-037 Async reset: drop rst_n between clock edges while iss_valid=1 -> iss_valid=0 and in_ready=1 immediately (no clock), and the queue is empty after release.
